// File: rtl/dmem_pkg.sv
// Shared data-memory constants and the loader state encoding.
package dmem_pkg;

    localparam int unsigned DMEM_ARRAY_BASE     = 1000;
    localparam int unsigned DMEM_MIN_VALUE_ADDR = 2000;
    localparam int unsigned DMEM_MIN_INDEX_ADDR = 2004;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite,
        StDone
    } loader_state_e;

endpackage

// File: rtl/dmem_loader_if.sv
// Byte stream, CPU data port, dmem port and loader status bundled for the loader.
interface dmem_loader_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             start;
    logic [CNT_W-1:0] num_words;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;

    logic [31:0]      cpu_adr;
    logic [31:0]      cpu_d_in;
    logic             cpu_mwr;
    logic             cpu_mrd;

    logic [31:0]      mem_adr;
    logic [31:0]      mem_d_in;
    logic             mem_mwr;
    logic             mem_mrd;

    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, num_words, byte_in, byte_valid,
        output cpu_adr, cpu_d_in, cpu_mwr, cpu_mrd,
        input  byte_ready, mem_adr, mem_d_in, mem_mwr, mem_mrd,
        input  cpu_hold, busy, done, err
    );

    modport slave (
        input  start, num_words, byte_in, byte_valid,
        input  cpu_adr, cpu_d_in, cpu_mwr, cpu_mrd,
        output byte_ready, mem_adr, mem_d_in, mem_mwr, mem_mrd,
        output cpu_hold, busy, done, err
    );

endinterface

// File: rtl/dmem_port_mux.sv
// Combinational select of the dmem port between the loader and the CPU.
module dmem_port_mux (
    input  logic        cpu_hold_i,
    input  logic [31:0] ld_adr_i,
    input  logic [31:0] ld_d_in_i,
    input  logic        ld_mwr_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_d_in_i,
    input  logic        cpu_mwr_i,
    input  logic        cpu_mrd_i,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_d_in_o,
    output logic        mem_mwr_o,
    output logic        mem_mrd_o
);

    always_comb begin
        if (cpu_hold_i) begin
            mem_adr_o  = ld_adr_i;
            mem_d_in_o = ld_d_in_i;
            mem_mwr_o  = ld_mwr_i;
            mem_mrd_o  = 1'b0;
        end else begin
            mem_adr_o  = cpu_adr_i;
            mem_d_in_o = cpu_d_in_i;
            mem_mwr_o  = cpu_mwr_i;
            mem_mrd_o  = cpu_mrd_i;
        end
    end

endmodule

// File: rtl/dmem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them into dmem
// from BASE_ADDR up, holding the CPU off until the load completes.
module dmem_loader
    import dmem_pkg::*;
#(
    parameter int unsigned BASE_ADDR = DMEM_ARRAY_BASE,
    parameter int unsigned MAX_WORDS = 20,
    parameter int unsigned CNT_W     = 16
) (
    input logic          clk,
    input logic          rst,
    dmem_loader_if.slave bus
);

    loader_state_e    state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [31:0]      word_q, word_d;
    logic             err_q, err_d;

    logic             ld_ready;
    logic             ld_mwr;
    logic [31:0]      ld_adr;
    logic [31:0]      ld_d_in;
    logic             hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            num_q      <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            num_q      <= num_d;
            word_q     <= word_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        num_d      = num_q;
        word_d     = word_q;
        err_d      = err_q;
        ld_ready   = 1'b0;
        ld_mwr     = 1'b0;
        ld_adr     = '0;
        ld_d_in    = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    err_d      = 1'b0;
                    num_d      = bus.num_words;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    if (bus.num_words == '0) begin
                        state_d = StDone;
                    end else if (32'(bus.num_words) > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                ld_ready = 1'b1;
                if (bus.byte_valid) begin
                    word_d[8*byte_cnt_q +: 8] = bus.byte_in;
                    byte_cnt_d                = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                ld_mwr     = 1'b1;
                ld_adr     = BASE_ADDR + 32'({word_idx_q, 2'b00});
                ld_d_in    = word_q;
                word_idx_d = word_idx_q + CNT_W'(1);
                byte_cnt_d = '0;
                // num_q is never zero here, so num_q-1 cannot wrap.
                state_d    = (word_idx_q == num_q - CNT_W'(1)) ? StDone : StCollect;
            end
            default: state_d = StIdle;
        endcase
    end

    assign hold           = (state_q != StDone);
    assign bus.byte_ready = ld_ready;
    assign bus.cpu_hold   = hold;
    assign bus.busy       = (state_q == StCollect) || (state_q == StWrite);
    assign bus.done       = (state_q == StDone);
    assign bus.err        = err_q;

    dmem_port_mux u_port_mux (
        .cpu_hold_i (hold),
        .ld_adr_i   (ld_adr),
        .ld_d_in_i  (ld_d_in),
        .ld_mwr_i   (ld_mwr),
        .cpu_adr_i  (bus.cpu_adr),
        .cpu_d_in_i (bus.cpu_d_in),
        .cpu_mwr_i  (bus.cpu_mwr),
        .cpu_mrd_i  (bus.cpu_mrd),
        .mem_adr_o  (bus.mem_adr),
        .mem_d_in_o (bus.mem_d_in),
        .mem_mwr_o  (bus.mem_mwr),
        .mem_mrd_o  (bus.mem_mrd)
    );

endmodule

// File: tb/tb_dmem_loader.sv
// Directed bench for dmem_loader: inputs driven and outputs sampled on the falling edge.
module tb_dmem_loader;

    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_loader_if #(.CNT_W(CNT_W)) bus ();

    dmem_loader #(
        .BASE_ADDR (1000),
        .MAX_WORDS (20),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] dmem [int];
    logic [31:0] wr_adr_q [$];
    logic [31:0] wr_dat_q [$];

    int arr [20] = '{12, 13, 21, 7, -3, 100, 42, 0, -11, 55,
                     9, -1, 33, 18, -50, 77, 5, 64, -20, -84};

    // A write strobe seen between edges commits on the next rising edge.
    always @(negedge clk) begin
        if (bus.mem_mwr) begin
            dmem[int'(bus.mem_adr)] = bus.mem_d_in;
            wr_adr_q.push_back(bus.mem_adr);
            wr_dat_q.push_back(bus.mem_d_in);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_adr_q.delete();
        wr_dat_q.delete();
        dmem.delete();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        bus.start     = 1'b1;
        bus.num_words = CNT_W'(n);
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rand_gap);
        int wait_n;
        if (rand_gap) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        wait_n         = 0;
        while (!bus.byte_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!bus.byte_ready) check_eq("byte_accept", 32'(bus.byte_ready), 32'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rand_gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rand_gap);
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!bus.done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_done", 32'(bus.done), 32'd1);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.num_words  = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.cpu_adr    = '0;
        bus.cpu_d_in   = '0;
        bus.cpu_mwr    = 1'b0;
        bus.cpu_mrd    = 1'b0;

        // Reset state
        do_reset(2);
        check_eq("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check_eq("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check_eq("rst_mem_mwr", 32'(bus.mem_mwr), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_mem_adr", bus.mem_adr, 32'd0);
        check_eq("rst_mem_d_in", bus.mem_d_in, 32'd0);

        // Single-word load
        clear_log();
        pulse_start(1);
        check_eq("n1_byte_ready", 32'(bus.byte_ready), 32'd1);
        check_eq("n1_busy", 32'(bus.busy), 32'd1);
        send_word(32'h0000000C, 1'b0);
        check_eq("n1_wr_mwr", 32'(bus.mem_mwr), 32'd1);
        check_eq("n1_wr_adr", bus.mem_adr, 32'd1000);
        check_eq("n1_wr_data", bus.mem_d_in, 32'h0000000C);
        check_eq("n1_wr_ready", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        check_eq("n1_done", 32'(bus.done), 32'd1);
        check_eq("n1_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        check_eq("n1_busy_off", 32'(bus.busy), 32'd0);
        check_eq("n1_wr_count", 32'(wr_adr_q.size()), 32'd1);

        // Full 20-word load with a bursty stream
        clear_log();
        pulse_start(20);
        check_eq("n20_hold", 32'(bus.cpu_hold), 32'd1);
        for (int i = 0; i < 20; i++) send_word(32'(arr[i]), 1'b1);
        wait_done(10);
        check_eq("n20_wr_count", 32'(wr_adr_q.size()), 32'd20);
        if (wr_adr_q.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                check_eq($sformatf("n20_adr%0d", i), wr_adr_q[i], 32'(1000 + 4 * i));
                check_eq($sformatf("n20_dat%0d", i), wr_dat_q[i], 32'(arr[i]));
            end
            check_eq("n20_word8", wr_dat_q[8], 32'hFFFFFFF5);
            check_eq("n20_word19", wr_dat_q[19], 32'hFFFFFFAC);
        end
        bus.cpu_mrd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.cpu_adr = 32'(1000 + 4 * i);
            #1;
            check_eq($sformatf("rd_adr%0d", i), bus.mem_adr, 32'(1000 + 4 * i));
            check_eq($sformatf("rd_dat%0d", i),
                     dmem.exists(int'(bus.mem_adr)) ? dmem[int'(bus.mem_adr)] : 32'hDEAD0000,
                     32'(arr[i]));
        end
        bus.cpu_mrd = 1'b0;
        bus.cpu_adr = '0;
        @(negedge clk);

        // Zero-length and oversize starts
        do_reset(2);
        clear_log();
        pulse_start(0);
        check_eq("n0_done", 32'(bus.done), 32'd1);
        check_eq("n0_err", 32'(bus.err), 32'd0);
        check_eq("n0_hold", 32'(bus.cpu_hold), 32'd0);
        pulse_start(21);
        check_eq("n21_err", 32'(bus.err), 32'd1);
        check_eq("n21_done", 32'(bus.done), 32'd1);
        check_eq("n21_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("n0_n21_no_writes", 32'(wr_adr_q.size()), 32'd0);
        pulse_start(0);
        check_eq("err_cleared", 32'(bus.err), 32'd0);

        // Reset mid-load, with a start ignored while busy
        do_reset(2);
        clear_log();
        pulse_start(3);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        bus.start     = 1'b1;
        bus.num_words = '0;
        @(negedge clk);
        bus.start     = 1'b0;
        check_eq("busy_start_ignored", 32'(bus.busy), 32'd1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_hold", 32'(bus.cpu_hold), 32'd1);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_done", 32'(bus.done), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.byte_ready), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("mid_rst_wr_count", 32'(wr_adr_q.size()), 32'd1);
        if (wr_adr_q.size() > 0) begin
            check_eq("mid_rst_wr_adr", wr_adr_q[0], 32'd1000);
            check_eq("mid_rst_wr_dat", wr_dat_q[0], 32'h44332211);
        end
        check_eq("mid_rst_no_1004", 32'(dmem.exists(1004)), 32'd0);

        // CPU pass-through after done, then blocked by a new start
        pulse_start(1);
        send_word(32'hDEADBEEF, 1'b0);
        wait_done(5);
        bus.cpu_mrd  = 1'b1;
        bus.cpu_adr  = 32'd1000;
        bus.cpu_d_in = 32'h12345678;
        #1;
        check_eq("pass_mrd", 32'(bus.mem_mrd), 32'd1);
        check_eq("pass_adr", bus.mem_adr, 32'd1000);
        check_eq("pass_d_in", bus.mem_d_in, 32'h12345678);
        check_eq("pass_rd_data", dmem.exists(1000) ? dmem[1000] : 32'd0, 32'hDEADBEEF);
        @(negedge clk);
        pulse_start(1);
        check_eq("block_hold", 32'(bus.cpu_hold), 32'd1);
        check_eq("block_mrd", 32'(bus.mem_mrd), 32'd0);
        check_eq("block_adr", bus.mem_adr, 32'd0);
        check_eq("block_d_in", bus.mem_d_in, 32'd0);
        check_eq("block_ready", 32'(bus.byte_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
